// File: rtl/taxi_pkg.sv
// Shared types and defaults for the taxi meter trip sequencer.
package taxi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_SETTLE = 2'd3
   } trip_state_t;

   localparam logic [19:0] CNT_MAX_DEFAULT = 20'd999_999;
   localparam logic [25:0] FREQ_DEFAULT    = 26'd50_000_000;

   // A trip is considered active in every state except IDLE.
   function automatic logic trip_active(input trip_state_t st);
      return st != ST_IDLE;
   endfunction

endpackage

// File: rtl/trip_ctrl_if.sv
// Key, distance strobe and sequencing-strobe bundle between the board side and trip_ctrl.
interface trip_ctrl_if;

   logic       key_start;
   logic       key_wait;
   logic       key_stop;
   logic       pulse_flag;
   logic [1:0] trip_stat;
   logic       meter_clr;
   logic       dist_en;
   logic       wait_en;
   logic       sec_tick;
   logic       disp_freeze;
   logic       seg_en;

   modport master (
      output key_start, key_wait, key_stop, pulse_flag,
      input  trip_stat, meter_clr, dist_en, wait_en, sec_tick, disp_freeze, seg_en
   );

   modport slave (
      input  key_start, key_wait, key_stop, pulse_flag,
      output trip_stat, meter_clr, dist_en, wait_en, sec_tick, disp_freeze, seg_en
   );

endinterface

// File: rtl/key_filter.sv
// Synchronises an active-low raw key, debounces it and emits a single press strobe
// once the key has been held low long enough; re-arms only after release.
module key_filter
   import taxi_pkg::*;
#(
   parameter logic [19:0] CNT_MAX = CNT_MAX_DEFAULT
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_n,
   output logic press
);

   logic        key_meta_q, key_meta_d;
   logic        key_sync_q, key_sync_d;
   logic [19:0] cnt_q, cnt_d;
   logic        held_q, held_d;
   logic        press_q, press_d;

   // The strobe is taken one edge after the counter saturates, and held_q blocks
   // any repeat until the synchronised key goes high again.
   always_comb begin
      key_meta_d = key_n;
      key_sync_d = key_meta_q;
      cnt_d      = cnt_q;
      held_d     = held_q;
      press_d    = 1'b0;
      if (key_sync_q) begin
         cnt_d  = 20'd0;
         held_d = 1'b0;
      end else begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 20'd1;
         end
         if ((cnt_q == CNT_MAX) && !held_q) begin
            press_d = 1'b1;
            held_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         key_meta_q <= 1'b1;
         key_sync_q <= 1'b1;
         cnt_q      <= 20'd0;
         held_q     <= 1'b0;
         press_q    <= 1'b0;
      end else begin
         key_meta_q <= key_meta_d;
         key_sync_q <= key_sync_d;
         cnt_q      <= cnt_d;
         held_q     <= held_d;
         press_q    <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/trip_ctrl.sv
// Taxi meter trip sequencer: debounced keys drive the IDLE/DRIVE/WAIT/SETTLE machine,
// which times seconds and strobes the fare datapath and display.
module trip_ctrl
   import taxi_pkg::*;
#(
   parameter logic [19:0] CNT_MAX     = CNT_MAX_DEFAULT,
   parameter logic [25:0] FREQ        = FREQ_DEFAULT,
   parameter logic [7:0]  AUTO_WAIT_S = 8'd10,
   parameter logic [7:0]  SETTLE_S    = 8'd30
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   trip_ctrl_if.slave    bus
);

   logic start_press, wait_press, stop_press;

   key_filter #(.CNT_MAX(CNT_MAX)) u_start (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .key_n   (bus.key_start),
      .press   (start_press)
   );

   key_filter #(.CNT_MAX(CNT_MAX)) u_wait (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .key_n   (bus.key_wait),
      .press   (wait_press)
   );

   key_filter #(.CNT_MAX(CNT_MAX)) u_stop (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .key_n   (bus.key_stop),
      .press   (stop_press)
   );

   trip_state_t state_q, state_d;
   logic [25:0] presc_q, presc_d;
   logic [7:0]  idle_sec_q, idle_sec_d;
   logic [7:0]  settle_sec_q, settle_sec_d;
   logic        meter_clr_q, meter_clr_d;
   logic        dist_en_q, dist_en_d;
   logic        wait_en_q, wait_en_d;
   logic        disp_freeze_q, disp_freeze_d;
   logic        seg_en_q, seg_en_d;

   logic sec_tick;
   logic auto_wait;
   logic settle_expiry;
   logic state_change;

   // A distance pulse in the same cycle as the last idle second cancels auto-wait.
   always_comb begin
      sec_tick      = trip_active(state_q) && (presc_q == FREQ - 26'd1);
      auto_wait     = (idle_sec_q == AUTO_WAIT_S - 8'd1) && sec_tick && !bus.pulse_flag;
      settle_expiry = (settle_sec_q == SETTLE_S - 8'd1) && sec_tick;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_press) state_d = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (stop_press)      state_d = ST_SETTLE;
            else if (wait_press) state_d = ST_WAIT;
            else if (auto_wait)  state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (stop_press)                         state_d = ST_SETTLE;
            else if (wait_press || bus.pulse_flag)  state_d = ST_DRIVE;
         end
         ST_SETTLE: begin
            if (start_press)        state_d = ST_DRIVE;
            else if (settle_expiry) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Every timer restarts from zero on entry to a new state.
   always_comb begin
      state_change = (state_d != state_q);
      presc_d      = presc_q + 26'd1;
      idle_sec_d   = idle_sec_q;
      settle_sec_d = settle_sec_q;
      if (!trip_active(state_q) || state_change || sec_tick) begin
         presc_d = 26'd0;
      end
      if (state_change || bus.pulse_flag) begin
         idle_sec_d = 8'd0;
      end else if ((state_q == ST_DRIVE) && sec_tick) begin
         idle_sec_d = idle_sec_q + 8'd1;
      end
      if (state_change) begin
         settle_sec_d = 8'd0;
      end else if ((state_q == ST_SETTLE) && sec_tick) begin
         settle_sec_d = settle_sec_q + 8'd1;
      end
   end

   // Strobes are decoded from the next state so they change on the same edge as trip_stat.
   always_comb begin
      meter_clr_d   = (state_d == ST_DRIVE) &&
                      ((state_q == ST_IDLE) || (state_q == ST_SETTLE));
      dist_en_d     = (state_d == ST_DRIVE) || (state_d == ST_WAIT);
      wait_en_d     = (state_d == ST_WAIT);
      disp_freeze_d = (state_d == ST_SETTLE);
      seg_en_d      = trip_active(state_d);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q       <= ST_IDLE;
         presc_q       <= 26'd0;
         idle_sec_q    <= 8'd0;
         settle_sec_q  <= 8'd0;
         meter_clr_q   <= 1'b0;
         dist_en_q     <= 1'b0;
         wait_en_q     <= 1'b0;
         disp_freeze_q <= 1'b0;
         seg_en_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         idle_sec_q    <= idle_sec_d;
         settle_sec_q  <= settle_sec_d;
         meter_clr_q   <= meter_clr_d;
         dist_en_q     <= dist_en_d;
         wait_en_q     <= wait_en_d;
         disp_freeze_q <= disp_freeze_d;
         seg_en_q      <= seg_en_d;
      end
   end

   assign bus.trip_stat   = state_q;
   assign bus.meter_clr   = meter_clr_q;
   assign bus.dist_en     = dist_en_q;
   assign bus.wait_en     = wait_en_q;
   assign bus.sec_tick    = sec_tick;
   assign bus.disp_freeze = disp_freeze_q;
   assign bus.seg_en      = seg_en_q;

endmodule

// File: tb/tb_trip_ctrl.sv
// Directed bench for trip_ctrl with short debounce and second timing.
module tb_trip_ctrl;

   logic sys_clk;
   logic sys_rst;
   int   vectors     = 0;
   int   miscompares = 0;

   trip_ctrl_if bus ();

   trip_ctrl #(
      .CNT_MAX     (20'd4),
      .FREQ        (26'd10),
      .AUTO_WAIT_S (8'd3),
      .SETTLE_S    (8'd2)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // Expected {trip_stat, meter_clr, dist_en, wait_en, sec_tick, disp_freeze, seg_en}.
   function automatic logic [7:0] exp_vec(input logic [1:0] st, input logic clr, input logic tick);
      return {st, clr, (st == 2'd1) || (st == 2'd2), st == 2'd2, tick, st == 2'd3, st != 2'd0};
   endfunction

   function automatic logic [7:0] obs_vec();
      return {bus.trip_stat, bus.meter_clr, bus.dist_en, bus.wait_en,
              bus.sec_tick, bus.disp_freeze, bus.seg_en};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%b required=%b", tag, obs, exp);
      end
   endtask

   // Hold the selected keys low; trip_stat must not move until the 8th edge.
   task automatic apply_stimulus(input logic [2:0] keys_low, input logic [1:0] stat_before,
                                 input string tag);
      bus.key_start = !keys_low[2];
      bus.key_wait  = !keys_low[1];
      bus.key_stop  = !keys_low[0];
      for (int i = 0; i < 7; i++) begin
         step(1);
         check_output({tag, "_latency"}, {6'd0, bus.trip_stat}, {6'd0, stat_before});
      end
      step(1);
   endtask

   task automatic release_keys();
      bus.key_start = 1'b1;
      bus.key_wait  = 1'b1;
      bus.key_stop  = 1'b1;
      step(3);
   endtask

   initial begin
      sys_rst        = 1'b1;
      bus.key_start  = 1'b1;
      bus.key_wait   = 1'b1;
      bus.key_stop   = 1'b1;
      bus.pulse_flag = 1'b0;
      step(3);
      sys_rst = 1'b0;
      check_output("reset", obs_vec(), exp_vec(2'd0, 1'b0, 1'b0));
      for (int i = 0; i < 5; i++) begin
         step(1);
         check_output("idle_quiet", obs_vec(), exp_vec(2'd0, 1'b0, 1'b0));
      end

      bus.key_start = 1'b0;
      step(3);
      bus.key_start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check_output("bounce", obs_vec(), exp_vec(2'd0, 1'b0, 1'b0));
      end

      bus.key_start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step(1);
         check_output("start_latency", obs_vec(), exp_vec(2'd0, 1'b0, 1'b0));
      end
      step(1);
      check_output("enter_drive", obs_vec(), exp_vec(2'd1, 1'b1, 1'b0));

      for (int k = 1; k <= 30; k++) begin
         logic [1:0] st;
         step(1);
         if (k == 2) bus.key_start = 1'b1;
         st = (k < 30) ? 2'd1 : 2'd2;
         check_output("auto_wait", obs_vec(), exp_vec(st, 1'b0, (k % 10) == 9));
      end

      bus.pulse_flag = 1'b1;
      step(1);
      bus.pulse_flag = 1'b0;
      check_output("wait_pulse", obs_vec(), exp_vec(2'd1, 1'b0, 1'b0));

      apply_stimulus(3'b011, 2'd1, "wait_stop");
      check_output("stop_wins", obs_vec(), exp_vec(2'd3, 1'b0, 1'b0));
      bus.key_wait = 1'b1;
      bus.key_stop = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         logic [1:0] st;
         step(1);
         st = (k < 20) ? 2'd3 : 2'd0;
         check_output("settle_expiry", obs_vec(), exp_vec(st, 1'b0, (k == 9) || (k == 19)));
      end

      apply_stimulus(3'b001, 2'd0, "idle_stop");
      check_output("idle_stop", obs_vec(), exp_vec(2'd0, 1'b0, 1'b0));
      release_keys();

      apply_stimulus(3'b100, 2'd0, "idle_start");
      check_output("idle_start", obs_vec(), exp_vec(2'd1, 1'b1, 1'b0));
      step(1);
      check_output("clr_once", obs_vec(), exp_vec(2'd1, 1'b0, 1'b0));
      release_keys();

      apply_stimulus(3'b001, 2'd1, "drive_stop");
      check_output("drive_stop", obs_vec(), exp_vec(2'd3, 1'b0, 1'b0));
      release_keys();

      apply_stimulus(3'b100, 2'd3, "settle_start");
      check_output("settle_start", obs_vec(), exp_vec(2'd1, 1'b1, 1'b0));
      step(1);
      check_output("settle_clr_once", obs_vec(), exp_vec(2'd1, 1'b0, 1'b0));
      release_keys();

      apply_stimulus(3'b010, 2'd1, "drive_wait");
      check_output("drive_wait", obs_vec(), exp_vec(2'd2, 1'b0, 1'b0));
      release_keys();
      check_output("still_wait", obs_vec(), exp_vec(2'd2, 1'b0, 1'b0));

      sys_rst = 1'b1;
      #1;
      check_output("async_reset", obs_vec(), exp_vec(2'd0, 1'b0, 1'b0));
      step(1);
      sys_rst = 1'b0;
      step(1);
      check_output("after_reset", obs_vec(), exp_vec(2'd0, 1'b0, 1'b0));
      bus.pulse_flag = 1'b1;
      step(1);
      bus.pulse_flag = 1'b0;
      check_output("idle_pulse", obs_vec(), exp_vec(2'd0, 1'b0, 1'b0));
      step(1);
      check_output("idle_pulse_late", obs_vec(), exp_vec(2'd0, 1'b0, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
